cp0_regs: RTL and testbench

Coprocessor-0 register file for the 5-stage MIPS pipeline. It is the responder for the decode stage's CP0 interface: it accepts MTC0 writes, returns MFC0 read data, and supplies EPC to the decode stage for ERET redirects. It also records precise exceptions signalled from the commit stage, runs the Count/Compare timer, and raises the interrupt request that the fetch/commit logic converts into an Int exception.

---
 rtl/cp0_pkg.sv | 49 ++++
 rtl/cp0_timer.sv | 53 +++++
 rtl/cp0_regs.sv | 154 +++++++++++++++
 tb/tb_cp0_regs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes and the
// packed layouts of Status and Cause.
package cp0_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned EXC_W = 5;

    localparam logic [IDX_W-1:0] CP0_BADVADDR = 5'd8;
    localparam logic [IDX_W-1:0] CP0_COUNT    = 5'd9;
    localparam logic [IDX_W-1:0] CP0_COMPARE  = 5'd11;
    localparam logic [IDX_W-1:0] CP0_STATUS   = 5'd12;
    localparam logic [IDX_W-1:0] CP0_CAUSE    = 5'd13;
    localparam logic [IDX_W-1:0] CP0_EPC      = 5'd14;

    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    typedef struct packed {
        logic [8:0] zero_hi;   // [31:23]
        logic       bev;       // [22]
        logic [5:0] zero_mid;  // [21:16]
        logic [7:0] im;        // [15:8]
        logic [5:0] zero_lo;   // [7:2]
        logic       exl;       // [1]
        logic       ie;        // [0]
    } status_t;

    typedef struct packed {
        logic        bd;        // [31]
        logic        ti;        // [30]
        logic [13:0] zero_hi;   // [29:16]
        logic [7:0]  ip;        // [15:8]
        logic        zero_mid;  // [7]
        logic [4:0]  exc_code;  // [6:2]
        logic [1:0]  zero_lo;   // [1:0]
    } cause_t;

    // Address-error exceptions are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [EXC_W-1:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare match and the TI flag.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            count_we,
    input  logic            compare_we,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] count,
    output logic [XLEN-1:0] compare,
    output logic            ti
);

    localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic             div_wrap;

    assign div_wrap = (div_q == DIV_W'(COUNT_DIV - 1));

    // Software load of Count restarts the prescaler so the next tick is a full period away.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_q <= '0;
            count <= '0;
        end else if (count_we) begin
            div_q <= '0;
            count <= wdata;
        end else begin
            div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
            if (div_wrap) begin
                count <= count + XLEN'(1);
            end
        end
    end

    // A Compare write acknowledges the timer interrupt and wins over a match.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            compare <= '0;
            ti      <= 1'b0;
        end else if (compare_we) begin
            compare <= wdata;
            ti      <= 1'b0;
        end else if ((count == compare) && (compare != '0)) begin
            ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: MTC0/MFC0 access, precise exception capture,
// ERET, interrupt pending/request logic and the Count/Compare timer.
module cp0_regs
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cp0_write,
    input  logic [IDX_W-1:0] cp0_idx,
    input  logic [XLEN-1:0]  cp0_data2w,
    output logic [XLEN-1:0]  cp0_val,
    output logic [XLEN-1:0]  d_epc,
    input  logic             exception,
    input  logic [EXC_W:0]   exc_excCode,
    input  logic [XLEN-1:0]  exc_pc,
    input  logic             exc_inDelaySlot,
    input  logic [XLEN-1:0]  exc_badvaddr,
    input  logic             eret,
    input  logic [5:0]       ext_int,
    output logic             int_req,
    output logic             status_exl
);

    logic            exc_taken;
    logic            wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    logic [7:0]      im;
    logic            exl;
    logic            ie;
    logic            bd;
    logic [EXC_W-1:0] exc_code;
    logic [1:0]      ip_sw;
    logic [5:0]      ip_hw;
    logic [5:0]      ext_sync;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] badvaddr;

    logic [XLEN-1:0] count;
    logic [XLEN-1:0] compare;
    logic            ti;

    status_t         status_rd;
    cause_t          cause_rd;
    logic [7:0]      ip_all;

    assign exc_taken  = exception & exc_excCode[EXC_W];
    assign wr_count   = cp0_write && (cp0_idx == CP0_COUNT);
    assign wr_compare = cp0_write && (cp0_idx == CP0_COMPARE);
    assign wr_status  = cp0_write && (cp0_idx == CP0_STATUS);
    assign wr_cause   = cp0_write && (cp0_idx == CP0_CAUSE);
    assign wr_epc     = cp0_write && (cp0_idx == CP0_EPC);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (cp0_data2w),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Hardware interrupt lines: one sync flop, then the IP mirror (timer shares IP7).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ext_sync <= '0;
            ip_hw    <= '0;
        end else begin
            ext_sync <= ext_int;
            ip_hw    <= {ext_sync[5] | ti, ext_sync[4:0]};
        end
    end

    // Exception entry outranks ERET, which outranks MTC0, on any shared field.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            exc_code <= '0;
            ip_sw    <= '0;
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            if (exc_taken) begin
                exl      <= 1'b1;
                exc_code <= exc_excCode[EXC_W-1:0];
                if (!exl) begin
                    epc <= exc_inDelaySlot ? exc_pc - XLEN'(4) : exc_pc;
                    bd  <= exc_inDelaySlot;
                end
                if (is_addr_exc(exc_excCode[EXC_W-1:0])) begin
                    badvaddr <= exc_badvaddr;
                end
            end else if (eret) begin
                exl <= 1'b0;
            end else if (wr_status) begin
                exl <= cp0_data2w[1];
            end

            if (wr_status) begin
                im <= cp0_data2w[15:8];
                ie <= cp0_data2w[0];
            end
            if (wr_cause) begin
                ip_sw <= cp0_data2w[9:8];
            end
            if (wr_epc && !exc_taken) begin
                epc <= cp0_data2w;
            end
        end
    end

    assign ip_all = {ip_hw, ip_sw};

    always_comb begin
        status_rd     = '0;
        status_rd.bev = 1'b1;
        status_rd.im  = im;
        status_rd.exl = exl;
        status_rd.ie  = ie;

        cause_rd          = '0;
        cause_rd.bd       = bd;
        cause_rd.ti       = ti;
        cause_rd.ip       = ip_all;
        cause_rd.exc_code = exc_code;
    end

    // MFC0 read mux over registered state; no write bypass.
    always_comb begin
        cp0_val = '0;
        case (cp0_idx)
            CP0_BADVADDR: cp0_val = badvaddr;
            CP0_COUNT:    cp0_val = count;
            CP0_COMPARE:  cp0_val = compare;
            CP0_STATUS:   cp0_val = status_rd;
            CP0_CAUSE:    cp0_val = cause_rd;
            CP0_EPC:      cp0_val = epc;
            default:      cp0_val = '0;
        endcase
    end

    assign d_epc      = epc;
    assign status_exl = exl;
    assign int_req    = ie & ~exl & (|(ip_all & im));

endmodule

// File: tb/tb_cp0_regs.sv
// Directed bench for cp0_regs: register access, exceptions, ERET, timer and interrupts.
module tb_cp0_regs;

    logic        clk;
    logic        resetn;
    logic        cp0_write;
    logic [4:0]  cp0_idx;
    logic [31:0] cp0_data2w;
    logic [31:0] cp0_val;
    logic [31:0] d_epc;
    logic        exception;
    logic [5:0]  exc_excCode;
    logic [31:0] exc_pc;
    logic        exc_inDelaySlot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  ext_int;
    logic        int_req;
    logic        status_exl;

    int vectors    = 0;
    int miscompares = 0;

    cp0_regs #(.COUNT_DIV(2)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .cp0_write       (cp0_write),
        .cp0_idx         (cp0_idx),
        .cp0_data2w      (cp0_data2w),
        .cp0_val         (cp0_val),
        .d_epc           (d_epc),
        .exception       (exception),
        .exc_excCode     (exc_excCode),
        .exc_pc          (exc_pc),
        .exc_inDelaySlot (exc_inDelaySlot),
        .exc_badvaddr    (exc_badvaddr),
        .eret            (eret),
        .ext_int         (ext_int),
        .int_req         (int_req),
        .status_exl      (status_exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] i, input logic [31:0] d);
        cp0_write  = 1'b1;
        cp0_idx    = i;
        cp0_data2w = d;
        tick();
        cp0_write  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] i, output logic [31:0] v);
        cp0_idx = i;
        #1;
        v = cp0_val;
    endtask

    task automatic raise(input logic [5:0] code, input logic [31:0] pc,
                         input logic ds, input logic [31:0] bva, input logic with_eret);
        exception       = 1'b1;
        exc_excCode     = code;
        exc_pc          = pc;
        exc_inDelaySlot = ds;
        exc_badvaddr    = bva;
        eret            = with_eret;
        tick();
        exception       = 1'b0;
        eret            = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        resetn = 1'b0;
        tick();
        tick();
        rd(5'd12, v);
        vectors++; if (v !== 32'h0040_0000) begin $display("FAIL reset_status got=%h exp=%h", v, 32'h0040_0000); miscompares++; end
        rd(5'd13, v);
        vectors++; if (v !== 32'h0) begin $display("FAIL reset_cause got=%h exp=0", v); miscompares++; end
        rd(5'd9, v);
        vectors++; if (v !== 32'h0) begin $display("FAIL reset_count got=%h exp=0", v); miscompares++; end
        rd(5'd0, v);
        vectors++; if (v !== 32'h0) begin $display("FAIL reset_idx0 got=%h exp=0", v); miscompares++; end
        vectors++; if (d_epc !== 32'h0) begin $display("FAIL reset_epc got=%h exp=0", d_epc); miscompares++; end
        vectors++; if ({int_req, status_exl} !== 2'b00) begin $display("FAIL reset_int_exl got=%b exp=00", {int_req, status_exl}); miscompares++; end
        resetn = 1'b1;
    endtask

    task automatic test_epc_write();
        logic [31:0] v;
        mtc0(5'd14, 32'hBFC0_1234);
        vectors++; if (d_epc !== 32'hBFC0_1234) begin $display("FAIL epc_d_epc got=%h exp=%h", d_epc, 32'hBFC0_1234); miscompares++; end
        rd(5'd14, v);
        vectors++; if (v !== 32'hBFC0_1234) begin $display("FAIL epc_read got=%h exp=%h", v, 32'hBFC0_1234); miscompares++; end
    endtask

    task automatic test_exception();
        logic [31:0] v;
        raise(6'h2A, 32'h8000_0100, 1'b1, 32'h0, 1'b0);
        vectors++; if (d_epc !== 32'h8000_00FC) begin $display("FAIL exc_epc_ds got=%h exp=%h", d_epc, 32'h8000_00FC); miscompares++; end
        rd(5'd13, v);
        vectors++; if (v !== 32'h8000_0028) begin $display("FAIL exc_cause got=%h exp=%h", v, 32'h8000_0028); miscompares++; end
        rd(5'd12, v);
        vectors++; if (v !== 32'h0040_0002) begin $display("FAIL exc_status got=%h exp=%h", v, 32'h0040_0002); miscompares++; end
        raise(6'h28, 32'h9000_0000, 1'b0, 32'h0, 1'b0);
        vectors++; if (d_epc !== 32'h8000_00FC) begin $display("FAIL nested_epc got=%h exp=%h", d_epc, 32'h8000_00FC); miscompares++; end
        rd(5'd13, v);
        vectors++; if (v !== 32'h8000_0020) begin $display("FAIL nested_cause got=%h exp=%h", v, 32'h8000_0020); miscompares++; end
        raise(6'h0C, 32'h9000_0040, 1'b0, 32'h0, 1'b0);
        rd(5'd13, v);
        vectors++; if (v !== 32'h8000_0020) begin $display("FAIL invalid_exc_cause got=%h exp=%h", v, 32'h8000_0020); miscompares++; end
    endtask

    task automatic test_adel_eret();
        logic [31:0] v;
        do_eret();
        vectors++; if (status_exl !== 1'b0) begin $display("FAIL eret_exl got=%b exp=0", status_exl); miscompares++; end
        raise(6'h24, 32'h8000_0200, 1'b0, 32'h0000_0003, 1'b1);
        rd(5'd8, v);
        vectors++; if (v !== 32'h3) begin $display("FAIL adel_badvaddr got=%h exp=3", v); miscompares++; end
        vectors++; if (status_exl !== 1'b1) begin $display("FAIL adel_eret_exl got=%b exp=1", status_exl); miscompares++; end
        vectors++; if (d_epc !== 32'h8000_0200) begin $display("FAIL adel_epc got=%h exp=%h", d_epc, 32'h8000_0200); miscompares++; end
        rd(5'd13, v);
        vectors++; if (v !== 32'h0000_0010) begin $display("FAIL adel_cause got=%h exp=%h", v, 32'h0000_0010); miscompares++; end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        do_eret();
        cp0_write  = 1'b1;
        cp0_idx    = 5'd12;
        cp0_data2w = 32'h0000_0001;
        raise(6'h2C, 32'h8000_0300, 1'b0, 32'h0, 1'b0);
        cp0_write  = 1'b0;
        rd(5'd12, v);
        vectors++; if (v !== 32'h0040_0003) begin $display("FAIL exc_vs_mtc0_status got=%h exp=%h", v, 32'h0040_0003); miscompares++; end
        vectors++; if (d_epc !== 32'h8000_0300) begin $display("FAIL exc_vs_mtc0_epc got=%h exp=%h", d_epc, 32'h8000_0300); miscompares++; end
        do_eret();
        rd(5'd12, v);
        vectors++; if (v !== 32'h0040_0001) begin $display("FAIL eret_status got=%h exp=%h", v, 32'h0040_0001); miscompares++; end
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_timer();
        logic [31:0] v;
        mtc0(5'd9, 32'h0000_1000);
        mtc0(5'd11, 32'd10);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        rd(5'd9, v);
        vectors++; if (v !== 32'd7) begin $display("FAIL timer_count got=%0d exp=7", v); miscompares++; end
        rd(5'd13, v);
        vectors++; if (v[30] !== 1'b0 || int_req !== 1'b0) begin $display("FAIL timer_early ti=%b int=%b exp=0,0", v[30], int_req); miscompares++; end
        for (int i = 0; i < 6; i++) tick();
        rd(5'd13, v);
        vectors++; if (v[30] !== 1'b1 || int_req !== 1'b0) begin $display("FAIL timer_ti_set ti=%b int=%b exp=1,0", v[30], int_req); miscompares++; end
        tick();
        vectors++; if (int_req !== 1'b1) begin $display("FAIL timer_int_req got=%b exp=1", int_req); miscompares++; end
        mtc0(5'd11, 32'd100);
        rd(5'd13, v);
        vectors++; if (v[30] !== 1'b0 || int_req !== 1'b1) begin $display("FAIL timer_ti_clear ti=%b int=%b exp=0,1", v[30], int_req); miscompares++; end
        tick();
        vectors++; if (int_req !== 1'b0) begin $display("FAIL timer_int_drop got=%b exp=0", int_req); miscompares++; end
        mtc0(5'd12, 32'h0);
        mtc0(5'd11, 32'h0);
    endtask

    task automatic test_ext_int();
        logic [31:0] v;
        mtc0(5'd12, 32'h0000_0401);
        ext_int = 6'b00_0001;
        tick();
        vectors++; if (int_req !== 1'b0) begin $display("FAIL ext_rise_1cyc got=%b exp=0", int_req); miscompares++; end
        tick();
        vectors++; if (int_req !== 1'b1) begin $display("FAIL ext_rise_2cyc got=%b exp=1", int_req); miscompares++; end
        rd(5'd13, v);
        vectors++; if (v[15:8] !== 8'h04) begin $display("FAIL ext_ip got=%h exp=04", v[15:8]); miscompares++; end
        ext_int = 6'b0;
        tick();
        vectors++; if (int_req !== 1'b1) begin $display("FAIL ext_fall_1cyc got=%b exp=1", int_req); miscompares++; end
        tick();
        vectors++; if (int_req !== 1'b0) begin $display("FAIL ext_fall_2cyc got=%b exp=0", int_req); miscompares++; end
    endtask

    task automatic test_sw_int();
        mtc0(5'd12, 32'h0000_0101);
        vectors++; if (int_req !== 1'b0) begin $display("FAIL sw_int_idle got=%b exp=0", int_req); miscompares++; end
        mtc0(5'd13, 32'h0000_0100);
        vectors++; if (int_req !== 1'b1) begin $display("FAIL sw_int_set got=%b exp=1", int_req); miscompares++; end
        raise(6'h20, 32'h8000_0400, 1'b0, 32'h0, 1'b0);
        vectors++; if (int_req !== 1'b0 || status_exl !== 1'b1) begin $display("FAIL int_entry int=%b exl=%b exp=0,1", int_req, status_exl); miscompares++; end
        vectors++; if (d_epc !== 32'h8000_0400) begin $display("FAIL int_entry_epc got=%h exp=%h", d_epc, 32'h8000_0400); miscompares++; end
    endtask

    task automatic test_field_masks();
        logic [31:0] v;
        mtc0(5'd3, 32'hFFFF_FFFF);
        rd(5'd3, v);
        vectors++; if (v !== 32'h0) begin $display("FAIL unimpl_read got=%h exp=0", v); miscompares++; end
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, v);
        vectors++; if (v !== 32'h0040_FF03) begin $display("FAIL status_mask got=%h exp=%h", v, 32'h0040_FF03); miscompares++; end
        vectors++; if (int_req !== 1'b0) begin $display("FAIL exl_masks_int got=%b exp=0", int_req); miscompares++; end
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v);
        vectors++; if (v !== 32'h0000_0300) begin $display("FAIL cause_mask got=%h exp=%h", v, 32'h0000_0300); miscompares++; end
        mtc0(5'd8, 32'h1234_5678);
        rd(5'd8, v);
        vectors++; if (v !== 32'h3) begin $display("FAIL badvaddr_ro got=%h exp=3", v); miscompares++; end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        rd(5'd12, v);
        vectors++; if (v !== 32'h0040_0000) begin $display("FAIL rst2_status got=%h exp=%h", v, 32'h0040_0000); miscompares++; end
        rd(5'd13, v);
        vectors++; if (v !== 32'h0) begin $display("FAIL rst2_cause got=%h exp=0", v); miscompares++; end
        rd(5'd9, v);
        vectors++; if (v !== 32'h0) begin $display("FAIL rst2_count got=%h exp=0", v); miscompares++; end
        vectors++; if ({int_req, status_exl} !== 2'b00 || d_epc !== 32'h0) begin $display("FAIL rst2_outs int=%b exl=%b epc=%h exp=0,0,0", int_req, status_exl, d_epc); miscompares++; end
    endtask

    initial begin
        resetn          = 1'b0;
        cp0_write       = 1'b0;
        cp0_idx         = '0;
        cp0_data2w      = '0;
        exception       = 1'b0;
        exc_excCode     = '0;
        exc_pc          = '0;
        exc_inDelaySlot = 1'b0;
        exc_badvaddr    = '0;
        eret            = 1'b0;
        ext_int         = '0;

        test_reset();
        test_epc_write();
        test_exception();
        test_adel_eret();
        test_priority();
        test_timer();
        test_ext_int();
        test_sw_int();
        test_field_masks();
        test_mid_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
